// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one structural ALU between two requesters.
// A round-robin arbiter grants one requester in IDLE, latches its operands
// and op select onto the ALU inputs, holds them for SETTLE_CYCLES edges so
// the ripple paths resolve, captures the result, and returns it over a
// valid/ready handshake to the owner only.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req{0,1}_valid/ready/a/b/op     request channels (ready is combinational)
//   resp{0,1}_valid/ready/data      response channels
//   alu_a, alu_b, alu_op            registered ALU inputs
//   alu_result                      combinational ALU output
//   busy                            high whenever the FSM is not idle
module alu_share_arbiter #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned OPW           = 3,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_data,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_data,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,

    output logic             busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam int unsigned    CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             resp0_valid_q, resp0_valid_d;
    logic             resp1_valid_q, resp1_valid_d;
    logic [WIDTH-1:0] resp0_data_q, resp0_data_d;
    logic [WIDTH-1:0] resp1_data_q, resp1_data_d;

    logic             gnt0_c, gnt1_c;

    // Round-robin grant: pointed-to requester first, else the other one.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (state_q == ST_IDLE) begin
            if (ptr_q) begin
                gnt1_c = req1_valid;
                gnt0_c = req0_valid & ~req1_valid;
            end else begin
                gnt0_c = req0_valid;
                gnt1_c = req1_valid & ~req0_valid;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        resp0_valid_d = resp0_valid_q;
        resp1_valid_d = resp1_valid_q;
        resp0_data_d  = resp0_data_q;
        resp1_data_d  = resp1_data_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt0_c) begin
                    alu_a_d  = req0_a;
                    alu_b_d  = req0_b;
                    alu_op_d = req0_op;
                    owner_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_SETTLE;
                end else if (gnt1_c) begin
                    alu_a_d  = req1_a;
                    alu_b_d  = req1_b;
                    alu_op_d = req1_op;
                    owner_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Capture on the last settle edge; only the owner's slot changes.
                if (cnt_q == CNT_LAST) begin
                    if (owner_q) begin
                        resp1_data_d  = alu_result;
                        resp1_valid_d = 1'b1;
                    end else begin
                        resp0_data_d  = alu_result;
                        resp0_valid_d = 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (owner_q ? resp1_ready : resp0_ready) begin
                    resp0_valid_d = 1'b0;
                    resp1_valid_d = 1'b0;
                    ptr_d         = ~owner_q;
                    state_d       = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 1'b0;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_data_q  <= '0;
            resp1_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_data_q  <= resp0_data_d;
            resp1_data_q  <= resp1_data_d;
        end
    end

    assign req0_ready  = gnt0_c;
    assign req1_ready  = gnt1_c;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp0_data  = resp0_data_q;
    assign resp1_data  = resp1_data_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single structural 32-bit ALU between two requesters (e.g. address-generation path and execute path).
- Arbitrates round-robin and latches the winner's operands and op select onto the ALU inputs.
- Holds the inputs stable for a fixed settle window so the gate-level ripple paths resolve, then captures the result.
- Returns the result to the winning requester over a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- OPW, 3, width of the ALU op select bus.
- SETTLE_CYCLES, 2, cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req0_op  input  OPW  requester 0 ALU op select
- resp0_valid  output  1  result for requester 0 available
- resp0_ready  input  1  requester 0 consumes result
- resp0_data  output  WIDTH  result for requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- resp1_valid, resp1_ready, resp1_data  same as requester 0, for requester 1
- alu_a  output  WIDTH  operand A driven to ALU
- alu_b  output  WIDTH  operand B driven to ALU
- alu_op  output  OPW  op select driven to ALU
- alu_result  input  WIDTH  combinational ALU output
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset values (any clk edge with rst_n=0):
  - state=IDLE; all ready/valid outputs 0.
  - alu_a, alu_b, alu_op, resp0_data and resp1_data all 0.
  - priority pointer = requester 0; settle counter = 0.
  - Reset is honoured mid-operation: any in-flight op is discarded and no response is issued.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - Grant goes to the pointed-to requester if its valid is high, else to the other requester if its valid is high.
  - reqN_ready=1 combinationally only for the granted requester, and only in IDLE. Ready may depend on valid.
  - Handshake completes when reqN_valid & reqN_ready are both 1 at an edge. At that edge:
    - register reqN_a/b/op into alu_a/b/op;
    - record the owner N;
    - counter=0; state goes to SETTLE.
- SETTLE:
  - alu_a/b/op are held constant.
  - Counter increments each edge.
  - At the edge where counter==SETTLE_CYCLES-1, alu_result is captured into respN_data (owner only), respN_valid is set, and state goes to RESP.
  - Latency: respN_valid is high exactly SETTLE_CYCLES cycles after the accepting edge.
- RESP:
  - respN_valid held high; respN_data held stable.
  - alu_* inputs keep their last values; new requests are not accepted.
  - At an edge with respN_ready=1: clear respN_valid; pointer goes to the other requester (1-N); state goes to IDLE.
  - The next accept occurs no earlier than the following edge, so there is one idle bubble between operations.
- Response data of the non-owner requester is never modified.
- Requesters must hold reqN_* stable while valid is high and not accepted. Operands are sampled only at the accept edge; later changes have no effect.
- The op value is passed through unchanged; the block does not interpret opcodes.
- No width extension or truncation is applied: alu_result is captured as-is.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 2 edges, all valids 0.
  - Required: all outputs 0, busy=0; req0_ready=req1_ready=0.
- Single op, SETTLE_CYCLES=2:
  - Stimulus: req0 a=0x0000_0005, b=0x0000_0003, op=ADD; bench ALU model adds.
  - Required: accept at edge E; resp0_valid=1 after edge E+2 with resp0_data=0x0000_0008; busy high from E until the resp handshake; resp1_valid stays 0.
- Simultaneous requests:
  - Stimulus: both valid at reset-exit.
  - Required: req0 wins first. After resp0 handshake, req1 is granted next (pointer=1). A third simultaneous request pair grants req0 again (alternation).
- Back-pressure:
  - Stimulus: resp1_ready held 0 for 10 cycles after resp1_valid rises; req0_valid=1 throughout.
  - Required: resp1_valid and resp1_data stable for all 10 cycles; req0_ready=0; alu_a/b/op unchanged.
- Operand change after accept:
  - Stimulus: change req0_a from 0xFFFF_FFFF to 0x0 the cycle after accept, op=AND with b=0x0000_00F0.
  - Required: resp0_data=0x0000_00F0.
- Reset mid-SETTLE:
  - Stimulus: rst_n=0 at the edge after accept.
  - Required: no resp valid ever asserted for that op; alu_* return to 0; next request from req1 alone is granted immediately after reset release.
